// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh
//   Power-up initialiser and auto-refresh scheduler for a single SDRAM.
//   It owns the command bus from reset until the mode register is loaded.
//   After that it takes single refresh slots whenever the access path
//   reports idle. Refreshes that fall due while the access path is busy
//   are counted, and ref_urgent lets the bus-cycle logic stall new RAM
//   accesses so the backlog can drain.
//
// Ports
//   MEMCLK        in   memory clock, all logic on the rising edge
//   RESET         in   synchronous reset, active-high
//   ctrl_idle     in   access path idle with all banks precharged
//   own_bus       out  1 = this block drives the command/address pins
//   cke           out  SDRAM clock enable
//   cs_n..we_n    out  SDRAM command
//   ma[11:0]      out  address (A10 for PRECHARGE ALL, mode word for MRS)
//   ba[1:0]       out  bank address, always 0
//   init_done     out  init sequence finished, sticky until RESET
//   ref_pending   out  refreshes owed
//   ref_urgent    out  ref_pending at saturation
//   ref_overflow  out  sticky, an interval expired while saturated
//
// Timing parameters TRP, TRFC and TMRD must be >= 2; each wait state
// lasts (param - 1) cycles after its one-cycle command.

`default_nettype none

module sdram_init_refresh #(
  parameter int          INIT_WAIT    = 10000,
  parameter int          INIT_REFS    = 8,
  parameter int          REF_INTERVAL = 780,
  parameter int          MAX_PENDING  = 4,
  parameter int          TRP          = 2,
  parameter int          TRFC         = 7,
  parameter int          TMRD         = 2,
  parameter logic [11:0] MODE_REG     = 12'h020
) (
  input  logic        MEMCLK,
  input  logic        RESET,
  input  logic        ctrl_idle,
  output logic        own_bus,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [11:0] ma,
  output logic [1:0]  ba,
  output logic        init_done,
  output logic [2:0]  ref_pending,
  output logic        ref_urgent,
  output logic        ref_overflow
);

  // state    | meaning
  // ---------+-----------------------------------------------------
  // S_RST    | held in reset: cke low, bus deselected
  // S_WAIT   | power-up NOP wait, INIT_WAIT cycles
  // S_PRE    | PRECHARGE ALL
  // S_TRP_W  | NOP, TRP-1 cycles
  // S_REF    | init AUTO REFRESH
  // S_RFC_W  | NOP, TRFC-1 cycles; loops to S_REF until INIT_REFS done
  // S_MRS    | LOAD MODE REGISTER
  // S_MRD_W  | NOP, TMRD-1 cycles
  // S_IDLE   | bus released to the access path
  // S_AREF   | scheduled AUTO REFRESH
  // S_ARFC_W | NOP, TRFC-1 cycles, then back to S_IDLE

  localparam int TMR_W = $clog2(INIT_WAIT + TRP + TRFC + TMRD + 1);
  localparam int RC_W  = $clog2(INIT_REFS + 1);
  localparam int IC_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  localparam logic [2:0]      MAX_P      = 3'(MAX_PENDING);
  localparam logic [IC_W-1:0] IVL_RELOAD = IC_W'(REF_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_RST,
    S_WAIT,
    S_PRE,
    S_TRP_W,
    S_REF,
    S_RFC_W,
    S_MRS,
    S_MRD_W,
    S_IDLE,
    S_AREF,
    S_ARFC_W
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [RC_W-1:0]  ref_cnt, ref_cnt_nxt;
  logic [IC_W-1:0]  ivl_cnt;
  logic             tmr_tc;
  logic             expire;
  logic             aref_issue;

  assign tmr_tc     = (tmr == '0);
  assign expire     = init_done && (ivl_cnt == '0);
  assign aref_issue = (state == S_AREF);
  assign ref_urgent = (ref_pending == MAX_P);
  assign ba         = 2'b00;

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      state   <= S_RST;
      tmr     <= '0;
      ref_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      ref_cnt <= ref_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr_tc ? tmr : tmr - 1'b1;
    ref_cnt_nxt = ref_cnt;

    own_bus = 1'b1;
    cke     = 1'b1;
    cs_n    = 1'b0;
    ras_n   = 1'b1;
    cas_n   = 1'b1;
    we_n    = 1'b1;
    ma      = 12'h000;

    case (state)
      S_RST: begin
        cke         = 1'b0;
        cs_n        = 1'b1;
        state_nxt   = S_WAIT;
        tmr_nxt     = TMR_W'(INIT_WAIT - 1);
        ref_cnt_nxt = '0;
      end
      S_WAIT: begin
        if (tmr_tc) state_nxt = S_PRE;
      end
      S_PRE: begin
        ras_n     = 1'b0;
        we_n      = 1'b0;
        ma        = 12'h400;
        state_nxt = S_TRP_W;
        tmr_nxt   = TMR_W'(TRP - 2);
      end
      S_TRP_W: begin
        if (tmr_tc) state_nxt = S_REF;
      end
      S_REF: begin
        ras_n       = 1'b0;
        cas_n       = 1'b0;
        state_nxt   = S_RFC_W;
        tmr_nxt     = TMR_W'(TRFC - 2);
        ref_cnt_nxt = ref_cnt + 1'b1;
      end
      S_RFC_W: begin
        if (tmr_tc) state_nxt = (ref_cnt == RC_W'(INIT_REFS)) ? S_MRS : S_REF;
      end
      S_MRS: begin
        ras_n     = 1'b0;
        cas_n     = 1'b0;
        we_n      = 1'b0;
        ma        = MODE_REG;
        state_nxt = S_MRD_W;
        tmr_nxt   = TMR_W'(TMRD - 2);
      end
      S_MRD_W: begin
        if (tmr_tc) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // Pins are deselected here; the access path's mux ignores them.
        own_bus = 1'b0;
        cs_n    = 1'b1;
        if ((ref_pending != '0) && ctrl_idle) state_nxt = S_AREF;
      end
      S_AREF: begin
        ras_n     = 1'b0;
        cas_n     = 1'b0;
        state_nxt = S_ARFC_W;
        tmr_nxt   = TMR_W'(TRFC - 2);
      end
      S_ARFC_W: begin
        if (tmr_tc) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

  // Refresh bookkeeping. The pending count is debited in the AREF cycle
  // itself, so by the time the FSM is back in S_IDLE the count is exact
  // and cannot trigger a duplicate refresh.
  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      ivl_cnt      <= IVL_RELOAD;
      init_done    <= 1'b0;
      ref_pending  <= 3'd0;
      ref_overflow <= 1'b0;
    end else begin
      if ((state == S_MRD_W) && tmr_tc) init_done <= 1'b1;

      if (!init_done || expire) ivl_cnt <= IVL_RELOAD;
      else                      ivl_cnt <= ivl_cnt - 1'b1;

      // An expiry coinciding with an AREF cancels out.
      if (expire && !aref_issue) begin
        if (ref_pending == MAX_P) ref_overflow <= 1'b1;
        else                      ref_pending  <= ref_pending + 1'b1;
      end else if (!expire && aref_issue) begin
        ref_pending <= ref_pending - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
